data_unpack_arb: RTL and testbench



---
 rtl/data_unpack_arb.sv | 168 ++++++++++++++++
 tb/tb_data_unpack_arb.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_unpack_arb.sv
// Packet-atomic round-robin arbiter feeding a single data_unpack instance.
// Optional macro DATA_UNPACK_ARB_SOP_CHECK_EN drops leading beats that lack sop.
module data_unpack_arb #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_sop,
    input  logic [NUM_SRC-1:0]        src_eop,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      dst_valid,
    output logic [DATA_W-1:0]         dst_data,
    output logic                      dst_sop,
    output logic                      dst_eop,
    output logic [ID_W-1:0]           dst_id,
    input  logic                      dst_ready,
    output logic                      busy,
    output logic                      sop_err
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     r_last_ptr;
    logic                r_first_beat;
    logic                r_dst_valid;
    logic [DATA_W-1:0]   r_dst_data;
    logic                r_dst_sop;
    logic                r_dst_eop;
    logic [ID_W-1:0]     r_dst_id;
    logic                r_sop_err;

    logic [ID_W-1:0]     w_win_id;
    logic                w_any_valid;
    logic                w_g_valid;
    logic [DATA_W-1:0]   w_g_data;
    logic                w_g_sop;
    logic                w_g_eop;
    logic                w_out_free;
    logic                w_accept;
    logic                w_drop;
    logic                w_load;
    logic                w_bad_sop;

    // Winner = valid source at the smallest cyclic distance past r_last_ptr.
    always_comb begin
        int v_dist;
        int v_best;
        w_win_id    = '0;
        w_any_valid = |src_valid;
        v_best      = NUM_SRC;
        v_dist      = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i]) begin
                v_dist = (i + NUM_SRC - 1 - int'(r_last_ptr)) % NUM_SRC;
                if (v_dist < v_best) begin
                    v_best   = v_dist;
                    w_win_id = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_g_valid = 1'b0;
        w_g_data  = '0;
        w_g_sop   = 1'b0;
        w_g_eop   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant_id == ID_W'(i)) begin
                w_g_valid = src_valid[i];
                w_g_data  = src_data[i*DATA_W +: DATA_W];
                w_g_sop   = src_sop[i];
                w_g_eop   = src_eop[i];
            end
        end
    end

    assign w_out_free = !r_dst_valid || dst_ready;
    assign w_accept   = (r_state == ST_BUSY) && w_g_valid && w_out_free;

`ifdef DATA_UNPACK_ARB_SOP_CHECK_EN
    assign w_drop = w_accept && r_first_beat && !w_g_sop;
`else
    assign w_drop = 1'b0;
`endif

    assign w_load    = w_accept && !w_drop;
    assign w_bad_sop = w_load && w_g_sop && !r_first_beat;

    always_comb begin
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_state == ST_BUSY && r_grant_id == ID_W'(i)) begin
                src_ready[i] = w_out_free;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant_id   <= '0;
            r_last_ptr   <= ID_W'(NUM_SRC - 1);
            r_first_beat <= 1'b0;
            r_dst_valid  <= 1'b0;
            r_dst_data   <= '0;
            r_dst_sop    <= 1'b0;
            r_dst_eop    <= 1'b0;
            r_dst_id     <= '0;
            r_sop_err    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_grant_id   <= w_win_id;
                        r_first_beat <= 1'b1;
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_accept) begin
                        if (w_load) begin
                            r_first_beat <= 1'b0;
                        end
                        // Dropped eop beats also close the grant.
                        if (w_g_eop) begin
                            r_last_ptr <= r_grant_id;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_load) begin
                r_dst_valid <= 1'b1;
                r_dst_data  <= w_g_data;
                r_dst_sop   <= w_g_sop;
                r_dst_eop   <= w_g_eop;
                r_dst_id    <= r_grant_id;
            end else if (dst_ready) begin
                r_dst_valid <= 1'b0;
            end

            if (w_bad_sop || w_drop) begin
                r_sop_err <= 1'b1;
            end
        end
    end

    assign dst_valid = r_dst_valid;
    assign dst_data  = r_dst_data;
    assign dst_sop   = r_dst_sop;
    assign dst_eop   = r_dst_eop;
    assign dst_id    = r_dst_id;
    assign busy      = (r_state == ST_BUSY);
    assign sop_err   = r_sop_err;

endmodule

// File: tb/tb_data_unpack_arb.sv
// Bench for data_unpack_arb: cycle tables, corner sequences, random traffic.
module tb_data_unpack_arb;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NS-1:0]    src_valid = '0;
    logic [NS*DW-1:0] src_data = '0;
    logic [NS-1:0]    src_sop = '0;
    logic [NS-1:0]    src_eop = '0;
    logic [NS-1:0]    src_ready;
    logic             dst_valid;
    logic [DW-1:0]    dst_data;
    logic             dst_sop;
    logic             dst_eop;
    logic [IW-1:0]    dst_id;
    logic             dst_ready = 1'b1;
    logic             busy;
    logic             sop_err;

    data_unpack_arb #(.NUM_SRC(NS), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_data(src_data),
        .src_sop(src_sop), .src_eop(src_eop), .src_ready(src_ready),
        .dst_valid(dst_valid), .dst_data(dst_data),
        .dst_sop(dst_sop), .dst_eop(dst_eop), .dst_id(dst_id),
        .dst_ready(dst_ready), .busy(busy), .sop_err(sop_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } beat_t;

    typedef struct packed {
        beat_t         b;
        logic [IW-1:0] id;
    } obs_t;

    typedef struct {
        bit          rst;
        logic [3:0]  val, sop, eop;
        logic [31:0] base;
        bit          rdy;
        logic [3:0]  srdy;
        bit          dv;
        logic [31:0] data;
        bit          s, e;
        logic [1:0]  id;
        bit          bsy, err, cd;
    } vec_t;

    vec_t  vq[$];
    beat_t src_q[NS][$];
    beat_t exp_q[NS][$];
    obs_t  mon_q[$];
    int    win_q[$];
    int    m_last;
    int    n_err = 0;
    int    n_chk = 0;
    obs_t  mon_v;

    always @(negedge clk) begin
        if (rst_n && dst_valid && dst_ready) begin
            mon_v.b.d = dst_data;
            mon_v.b.s = dst_sop;
            mon_v.b.e = dst_eop;
            mon_v.id  = dst_id;
            mon_q.push_back(mon_v);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(int rst, int val, int sop, int eop, int base,
                                int rdy, int srdy, int dv, int data, int s,
                                int e, int id, int bsy, int err, int cd);
        vec_t v;
        v.rst = rst[0]; v.val = val[3:0]; v.sop = sop[3:0]; v.eop = eop[3:0];
        v.base = base; v.rdy = rdy[0]; v.srdy = srdy[3:0]; v.dv = dv[0];
        v.data = data; v.s = s[0]; v.e = e[0]; v.id = id[1:0];
        v.bsy = bsy[0]; v.err = err[0]; v.cd = cd[0];
        return v;
    endfunction

    function automatic int rr_pick(int last, logic [NS-1:0] v);
        for (int k = 1; k <= NS; k++) begin
            if (v[(last + k) % NS]) return (last + k) % NS;
        end
        return -1;
    endfunction

    task automatic load_lanes();
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                src_data[i*DW +: DW] = src_q[i][0].d;
                src_sop[i] = src_q[i][0].s;
                src_eop[i] = src_q[i][0].e;
            end
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        src_valid = '0; src_sop = '0; src_eop = '0;
        dst_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        m_last = NS - 1;
        mon_q.delete();
        win_q.delete();
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
    endtask

    task automatic add_beat(int src, logic [31:0] d, bit s, bit e);
        beat_t b;
        b.d = d; b.s = s; b.e = e;
        src_q[src].push_back(b);
        exp_q[src].push_back(b);
    endtask

    task automatic run_traffic(input int budget, input int gap, input int rdyp);
        logic [NS-1:0] acc;
        int cyc;
        int left;
        bit done;
        for (int i = 0; i < NS; i++)
            src_valid[i] = (src_q[i].size() > 0) && ($urandom_range(99) >= gap);
        load_lanes();
        dst_ready = ($urandom_range(99) < rdyp);
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            acc = src_valid & src_ready;
            chk("ready_onehot0", 64'($countones(src_ready) <= 1), 64'd1);
            if (!busy && |src_valid) win_q.push_back(rr_pick(m_last, src_valid));
            for (int i = 0; i < NS; i++)
                if (acc[i] && src_eop[i]) m_last = i;
            tick();
            for (int i = 0; i < NS; i++) begin
                if (acc[i]) void'(src_q[i].pop_front());
                if (!(src_valid[i] && !acc[i]))
                    src_valid[i] = (src_q[i].size() > 0) && ($urandom_range(99) >= gap);
            end
            load_lanes();
            dst_ready = ($urandom_range(99) < rdyp);
            cyc++;
            left = 0;
            for (int i = 0; i < NS; i++) left += src_q[i].size();
            done = (left == 0) && !busy && !dst_valid;
        end
        chk("traffic_done", 64'(done), 64'd1);
        dst_ready = 1'b1;
        src_valid = '0;
    endtask

    task automatic check_stream();
        bit in_pkt;
        int cur;
        obs_t o;
        in_pkt = 1'b0;
        cur = 0;
        for (int j = 0; j < mon_q.size(); j++) begin
            o = mon_q[j];
            if (in_pkt) begin
                chk("atomic_id", 64'(o.id), 64'(cur));
            end else begin
                chk("pkt_first_sop", 64'(o.b.s), 64'd1);
                if (win_q.size() == 0) chk("rr_missing", 64'd1, 64'd0);
                else chk("rr_winner", 64'(o.id), 64'(win_q.pop_front()));
            end
            if (exp_q[o.id].size() == 0) chk("extra_beat", 64'd1, 64'd0);
            else chk("beat", 64'(o.b), 64'(exp_q[o.id].pop_front()));
            in_pkt = !o.b.e;
            cur = o.id;
        end
        for (int i = 0; i < NS; i++) chk("beats_left", 64'(exp_q[i].size()), 64'd0);
        chk("wins_left", 64'(win_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int ids[4];
        logic [31:0] dat[4];
        int plen;

        // Table: reset state, 3-beat packet from src0, then 1-beat rotation.
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 1, 1, 0, 'hA000_0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 1, 0, 'hA000_0000, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 1, 0, 0, 'hA000_0010, 1, 1, 1, 'hA000_0000, 1, 0, 0, 1, 0, 1));
        vq.push_back(mk(1, 1, 0, 1, 'hA000_0020, 1, 1, 1, 'hA000_0010, 0, 0, 0, 1, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 'hA000_0020, 0, 1, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 15, 15, 15, 'hB000_0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 15, 15, 15, 'hB000_0000, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 15, 15, 15, 'hB000_0000, 1, 0, 1, 'hB000_0000, 1, 1, 0, 0, 0, 1));
        vq.push_back(mk(1, 15, 15, 15, 'hB000_0000, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 15, 15, 15, 'hB000_0000, 1, 0, 1, 'hB000_0001, 1, 1, 1, 0, 0, 1));
        vq.push_back(mk(1, 15, 15, 15, 'hB000_0000, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 15, 15, 15, 'hB000_0000, 1, 0, 1, 'hB000_0002, 1, 1, 2, 0, 0, 1));
        vq.push_back(mk(1, 15, 15, 15, 'hB000_0000, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 15, 15, 15, 'hB000_0000, 1, 0, 1, 'hB000_0003, 1, 1, 3, 0, 0, 1));
        vq.push_back(mk(1, 15, 15, 15, 'hB000_0000, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 15, 15, 15, 'hB000_0000, 1, 0, 1, 'hB000_0000, 1, 1, 0, 0, 0, 1));

        for (int r = 0; r < vq.size(); r++) begin
            v = vq[r];
            rst_n = v.rst;
            src_valid = v.val;
            src_sop = v.sop;
            src_eop = v.eop;
            for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = v.base + 32'(i);
            dst_ready = v.rdy;
            @(negedge clk);
            if (v.rst) begin
                chk($sformatf("t%0d_src_ready", r), 64'(src_ready), 64'(v.srdy));
                chk($sformatf("t%0d_dst_valid", r), 64'(dst_valid), 64'(v.dv));
                chk($sformatf("t%0d_busy", r), 64'(busy), 64'(v.bsy));
                chk($sformatf("t%0d_sop_err", r), 64'(sop_err), 64'(v.err));
                if (v.cd) begin
                    chk($sformatf("t%0d_dst_data", r), 64'(dst_data), 64'(v.data));
                    chk($sformatf("t%0d_dst_sop", r), 64'(dst_sop), 64'(v.s));
                    chk($sformatf("t%0d_dst_eop", r), 64'(dst_eop), 64'(v.e));
                    chk($sformatf("t%0d_dst_id", r), 64'(dst_id), 64'(v.id));
                end
            end
            tick();
        end

        // Two 2-beat packets contend; packets must not interleave.
        reset_dut();
        add_beat(1, 32'h1000_0010, 1, 0);
        add_beat(1, 32'h1000_0011, 0, 1);
        add_beat(2, 32'h2000_0020, 1, 0);
        add_beat(2, 32'h2000_0021, 0, 1);
        run_traffic(200, 0, 100);
        ids = '{1, 1, 2, 2};
        dat = '{32'h1000_0010, 32'h1000_0011, 32'h2000_0020, 32'h2000_0021};
        chk("grp_count", 64'(mon_q.size()), 64'd4);
        if (mon_q.size() == 4) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("grp_id%0d", j), 64'(mon_q[j].id), 64'(ids[j]));
                chk($sformatf("grp_data%0d", j), 64'(mon_q[j].b.d), 64'(dat[j]));
            end
        end

        // Backpressure held for 5 cycles mid-packet.
        reset_dut();
        src_valid = 4'b0001; src_sop = 4'b0001; src_eop = '0;
        src_data[0 +: DW] = 32'hC000_0000;
        dst_ready = 1'b1;
        tick();
        tick();
        src_data[0 +: DW] = 32'hC000_0001;
        src_sop = '0;
        dst_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 64'(dst_valid), 64'd1);
            chk("stall_data", 64'(dst_data), 64'h0000_0000_C000_0000);
            chk("stall_ready", 64'(src_ready), 64'd0);
            tick();
        end
        dst_ready = 1'b1;
        tick();
        src_data[0 +: DW] = 32'hC000_0002;
        src_eop = 4'b0001;
        tick();
        src_valid = '0; src_eop = '0;
        tick();
        tick();
        chk("stall_count", 64'(mon_q.size()), 64'd3);
        if (mon_q.size() == 3) begin
            for (int j = 0; j < 3; j++)
                chk($sformatf("stall_beat%0d", j), 64'(mon_q[j].b.d), 64'(32'hC000_0000 + 32'(j)));
        end

        // Mid-packet sop flags an error but every beat is forwarded.
        reset_dut();
        add_beat(0, 32'hE000_0000, 1, 0);
        add_beat(0, 32'hE000_0001, 1, 0);
        add_beat(0, 32'hE000_0002, 0, 1);
        chk("err_before", 64'(sop_err), 64'd0);
        run_traffic(200, 0, 100);
        chk("err_count", 64'(mon_q.size()), 64'd3);
        if (mon_q.size() == 3) begin
            for (int j = 0; j < 3; j++)
                chk($sformatf("err_beat%0d", j), 64'(mon_q[j].b.d), 64'(32'hE000_0000 + 32'(j)));
        end
        chk("err_set", 64'(sop_err), 64'd1);
        repeat (3) tick();
        chk("err_sticky", 64'(sop_err), 64'd1);

        // Leading beat without sop from src3.
        reset_dut();
        add_beat(3, 32'hF000_0000, 0, 0);
        add_beat(3, 32'hF000_0001, 1, 1);
        run_traffic(200, 0, 100);
        chk("lead_err", 64'(sop_err), 64'd1);
`ifdef DATA_UNPACK_ARB_SOP_CHECK_EN
        chk("lead_count", 64'(mon_q.size()), 64'd1);
        if (mon_q.size() == 1) begin
            chk("lead_data", 64'(mon_q[0].b.d), 64'h0000_0000_F000_0001);
            chk("lead_id", 64'(mon_q[0].id), 64'd3);
        end
`else
        chk("lead_count", 64'(mon_q.size()), 64'd2);
        if (mon_q.size() == 2) begin
            chk("lead_data", 64'(mon_q[0].b.d), 64'h0000_0000_F000_0000);
            chk("lead_id", 64'(mon_q[1].id), 64'd3);
        end
`endif

        // Random well-formed traffic against the scoreboard and RR model.
        for (int rnd = 0; rnd < 3; rnd++) begin
            reset_dut();
            for (int i = 0; i < NS; i++) begin
                for (int p = 0; p < 6; p++) begin
                    plen = $urandom_range(4, 1);
                    for (int b = 0; b < plen; b++)
                        add_beat(i, $urandom, b == 0, b == plen - 1);
                end
            end
            run_traffic(5000, 30 * rnd, 90 - 25 * rnd);
            check_stream();
            chk("rand_no_err", 64'(sop_err), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
